// File: rtl/wb_arbiter_pkg.sv
// Writeback arbiter shared definitions.
// Bus widths, control levels, result bundle and source select.
package wb_arbiter_pkg;

   localparam int REG_BUS_W  = 32;
   localparam int REG_ADDR_W = 5;
   localparam int REG_NUM    = 32;

   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam logic RST_ENABLE    = 1'b1;

   localparam int QDEPTH_DEF = 4;

   localparam logic [1:0] STARVE_MAX = 2'd3;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_BUS_W-1:0]  data;
   } wb_res_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_ALU,
      SRC_HEAD,
      SRC_BYP
   } wb_src_e;

   function automatic logic [REG_NUM-1:0] rd_onehot(
      input logic [REG_ADDR_W-1:0] rd
   );
      logic [REG_NUM-1:0] v;
      v     = '0;
      v[rd] = 1'b1;
      v[0]  = 1'b0;
      return v;
   endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle.
// Producer ports, register-file write port and pending mask.
interface wb_arbiter_if
   import wb_arbiter_pkg::*;
();

   logic                  alu_valid_in;
   logic [REG_ADDR_W-1:0] alu_rd_in;
   logic [REG_BUS_W-1:0]  alu_data_in;
   logic                  alu_ready_out;

   logic                  mem_valid_in;
   logic [REG_ADDR_W-1:0] mem_rd_in;
   logic [REG_BUS_W-1:0]  mem_data_in;
   logic                  mem_ready_out;

   logic                  we_out;
   logic [REG_ADDR_W-1:0] waddr_out;
   logic [REG_BUS_W-1:0]  wdata_out;
   logic [REG_NUM-1:0]    pending_out;

   modport slave (
      input  alu_valid_in, alu_rd_in, alu_data_in,
      input  mem_valid_in, mem_rd_in, mem_data_in,
      output alu_ready_out, mem_ready_out,
      output we_out, waddr_out, wdata_out,
      output pending_out
   );

   modport master (
      output alu_valid_in, alu_rd_in, alu_data_in,
      output mem_valid_in, mem_rd_in, mem_data_in,
      input  alu_ready_out, mem_ready_out,
      input  we_out, waddr_out, wdata_out,
      input  pending_out
   );

endinterface

// File: rtl/wb_fifo.sv
// Memory-result queue for the writeback arbiter.
// In-order FIFO with per-entry valid bits feeding a pending mask.
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = QDEPTH_DEF
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   push,
   input  logic                   pop,
   input  wb_res_t                din,
   output wb_res_t                head,
   output logic [$clog2(DEPTH):0] count,
   output logic [REG_NUM-1:0]     pending
);

   localparam int PW = $clog2(DEPTH);

   wb_res_t         ent [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      cnt;

   // pointers wrap by natural overflow; vld tracks live slots
   always_ff @(posedge clk_in) begin
      if (rst_in == RST_ENABLE) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         vld    <= '0;
      end else begin
         if (push) begin
            wr_ptr      <= wr_ptr + 1'b1;
            vld[wr_ptr] <= 1'b1;
         end
         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            vld[rd_ptr] <= 1'b0;
         end
         cnt <= cnt + {{PW{1'b0}}, push}
                    - {{PW{1'b0}}, pop};
      end
   end

   // payload storage, no reset needed behind vld
   always_ff @(posedge clk_in) begin
      if (push) begin
         ent[wr_ptr] <= din;
      end
   end

   assign head  = ent[rd_ptr];
   assign count = cnt;

   // registers targeted by any live entry
   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld[i]) begin
            pending = pending | rd_onehot(ent[i].rd);
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU and load results onto one RF write port.
// ALU has priority; loads queue behind it with a starvation guard.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int QDEPTH = QDEPTH_DEF
) (
   input  logic        clk_in,
   input  logic        rst_in,
   wb_arbiter_if.slave bus
);

   localparam int CW = $clog2(QDEPTH) + 1;

   logic [CW-1:0]      count;
   logic [1:0]         starve_q;
   logic [1:0]         starve_d;
   wb_res_t            head;
   wb_res_t            mem_res;
   wb_res_t            wr;
   wb_src_e            src;
   logic [REG_NUM-1:0] pend;
   logic               q_empty;
   logic               q_full;
   logic               alu_rdy;
   logic               mem_rdy;
   logic               alu_w;
   logic               mem_w;
   logic               push;
   logic               pop;
   logic               we_q;
   logic [REG_ADDR_W-1:0] waddr_q;
   logic [REG_BUS_W-1:0]  wdata_q;

   assign q_empty = (count == '0);
   assign q_full  = (count == CW'(QDEPTH));

   assign alu_rdy = (rst_in != RST_ENABLE)
                 && !(!q_empty && starve_q == STARVE_MAX);
   assign mem_rdy = (rst_in != RST_ENABLE) && !q_full;

   // rd==0 transfers are accepted but never compete for the port
   assign alu_w = bus.alu_valid_in && alu_rdy
               && (bus.alu_rd_in != '0);
   assign mem_w = bus.mem_valid_in && mem_rdy
               && (bus.mem_rd_in != '0);

   assign mem_res = {bus.mem_rd_in, bus.mem_data_in};

   // pick the write source: ALU, queue head, then bypass
   always_comb begin
      src = SRC_NONE;
      wr  = head;
      if (alu_w) begin
         src = SRC_ALU;
         wr  = {bus.alu_rd_in, bus.alu_data_in};
      end else if (!q_empty) begin
         src = SRC_HEAD;
      end else if (mem_w) begin
         src = SRC_BYP;
         wr  = mem_res;
      end
   end

   assign pop  = (src == SRC_HEAD);
   assign push = mem_w && (src != SRC_BYP);

   // count ALU wins over a waiting queue, saturating
   always_comb begin
      starve_d = starve_q;
      if (q_empty || pop) begin
         starve_d = '0;
      end else if (alu_w && starve_q != STARVE_MAX) begin
         starve_d = starve_q + 2'd1;
      end
   end

   // registered write port and starve state
   always_ff @(posedge clk_in) begin
      if (rst_in == RST_ENABLE) begin
         starve_q <= '0;
         we_q     <= WRITE_DISABLE;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         starve_q <= starve_d;
         we_q     <= (src != SRC_NONE) ? WRITE_ENABLE
                                       : WRITE_DISABLE;
         if (src != SRC_NONE) begin
            waddr_q <= wr.rd;
            wdata_q <= wr.data;
         end
      end
   end

   wb_fifo #(
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .push    (push),
      .pop     (pop),
      .din     (mem_res),
      .head    (head),
      .count   (count),
      .pending (pend)
   );

   assign bus.alu_ready_out = alu_rdy;
   assign bus.mem_ready_out = mem_rdy;
   assign bus.we_out        = we_q;
   assign bus.waddr_out     = waddr_q;
   assign bus.wdata_out     = wdata_q;
   assign bus.pending_out   = pend;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter.
// Directed scenarios plus random traffic against a queue model.
module tb_wb_arbiter;

   localparam int QD = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } res_t;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;

   always #5 clk_in = ~clk_in;

   wb_arbiter_if bus ();

   wb_arbiter #(
      .QDEPTH (QD)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   res_t        mq[$];
   int          m_starve = 0;
   logic        m_we = 1'b0;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_wdata = '0;

   bit aa, ma;

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_pend();
      logic [31:0] p;
      p = '0;
      foreach (mq[i]) p[mq[i].rd] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   task automatic step(output bit a_acc, output bit m_acc);
      bit          ardy, mrdy, a, m, r;
      int          n;
      res_t        e;
      logic [4:0]  ard, mrd;
      logic [31:0] adat, mdat;
      #1;
      r    = rst_in;
      ardy = !r && !(mq.size() != 0 && m_starve == 3);
      mrdy = !r && (mq.size() != QD);
      chk("alu_ready", {31'd0, bus.alu_ready_out}, {31'd0, ardy});
      chk("mem_ready", {31'd0, bus.mem_ready_out}, {31'd0, mrdy});
      a_acc = bus.alu_valid_in && ardy;
      m_acc = bus.mem_valid_in && mrdy;
      ard   = bus.alu_rd_in;
      adat  = bus.alu_data_in;
      mrd   = bus.mem_rd_in;
      mdat  = bus.mem_data_in;
      a     = a_acc && ard != 0;
      m     = m_acc && mrd != 0;
      @(posedge clk_in);
      if (r) begin
         mq.delete();
         m_starve = 0;
         m_we     = 1'b0;
         m_waddr  = '0;
         m_wdata  = '0;
      end else begin
         n    = mq.size();
         m_we = 1'b0;
         if (a) begin
            m_we    = 1'b1;
            m_waddr = ard;
            m_wdata = adat;
            if (m) mq.push_back(res_t'({mrd, mdat}));
            if (n == 0) m_starve = 0;
            else if (m_starve < 3) m_starve++;
         end else if (n != 0) begin
            e       = mq.pop_front();
            m_we    = 1'b1;
            m_waddr = e.rd;
            m_wdata = e.data;
            if (m) mq.push_back(res_t'({mrd, mdat}));
            m_starve = 0;
         end else begin
            if (m) begin
               m_we    = 1'b1;
               m_waddr = mrd;
               m_wdata = mdat;
            end
            m_starve = 0;
         end
      end
      #1;
      chk("we", {31'd0, bus.we_out}, {31'd0, m_we});
      chk("waddr", {27'd0, bus.waddr_out}, {27'd0, m_waddr});
      chk("wdata", bus.wdata_out, m_wdata);
      chk("pending", bus.pending_out, exp_pend());
   endtask

   task automatic idle_in();
      bus.alu_valid_in = 1'b0;
      bus.alu_rd_in    = '0;
      bus.alu_data_in  = '0;
      bus.mem_valid_in = 1'b0;
      bus.mem_rd_in    = '0;
      bus.mem_data_in  = '0;
   endtask

   initial begin
      int         ai, mi, left;
      bit         saw_mlo, saw_alo;
      logic [4:0] seen[$];

      idle_in();
      rst_in = 1'b1;
      step(aa, ma);
      step(aa, ma);
      rst_in = 1'b0;

      // ALU write right after reset release
      bus.alu_valid_in = 1'b1;
      bus.alu_rd_in    = 5'd5;
      bus.alu_data_in  = 32'h11;
      step(aa, ma);
      chk("r028_we", {31'd0, bus.we_out}, 32'd1);
      chk("r028_waddr", {27'd0, bus.waddr_out}, 32'd5);
      chk("r028_wdata", bus.wdata_out, 32'h11);
      idle_in();
      step(aa, ma);
      chk("r028_we_n2", {31'd0, bus.we_out}, 32'd0);

      // bypass load
      bus.mem_valid_in = 1'b1;
      bus.mem_rd_in    = 5'd7;
      bus.mem_data_in  = 32'hAB;
      step(aa, ma);
      chk("r029_waddr", {27'd0, bus.waddr_out}, 32'd7);
      chk("r029_wdata", bus.wdata_out, 32'hAB);
      chk("r029_pend", bus.pending_out, 32'd0);
      idle_in();
      step(aa, ma);

      // simultaneous ALU and load
      bus.alu_valid_in = 1'b1;
      bus.alu_rd_in    = 5'd3;
      bus.alu_data_in  = 32'h33;
      bus.mem_valid_in = 1'b1;
      bus.mem_rd_in    = 5'd4;
      bus.mem_data_in  = 32'h44;
      step(aa, ma);
      chk("r030_waddr1", {27'd0, bus.waddr_out}, 32'd3);
      chk("r030_pend1", bus.pending_out, 32'h10);
      idle_in();
      step(aa, ma);
      chk("r030_waddr2", {27'd0, bus.waddr_out}, 32'd4);
      chk("r030_wdata2", bus.wdata_out, 32'h44);
      chk("r030_pend2", bus.pending_out, 32'd0);

      // five loads against a continuously valid ALU
      ai      = 0;
      mi      = 0;
      saw_mlo = 1'b0;
      saw_alo = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (mi == 5 && mq.size() == 0) break;
         bus.alu_valid_in = (c < 40);
         bus.alu_rd_in    = 5'(1 + ai % 9);
         bus.alu_data_in  = {8'hC0, 24'(ai)};
         bus.mem_valid_in = (mi < 5);
         bus.mem_rd_in    = 5'(10 + mi);
         bus.mem_data_in  = {8'hA5, 24'(mi)};
         step(aa, ma);
         if (aa) ai++;
         if (ma) mi++;
         if (bus.we_out && bus.wdata_out[31:24] == 8'hA5)
            seen.push_back(bus.waddr_out);
         if (!bus.mem_ready_out) saw_mlo = 1'b1;
         if (!bus.alu_ready_out) saw_alo = 1'b1;
      end
      idle_in();
      chk("r031_loads", mi, 5);
      chk("r031_drained", mq.size(), 0);
      chk("r031_mlo", {31'd0, saw_mlo}, 32'd1);
      chk("r031_alo", {31'd0, saw_alo}, 32'd1);
      chk("r031_nwr", seen.size(), 5);
      foreach (seen[i])
         chk("r031_order", {27'd0, seen[i]}, 32'(10 + i));
      step(aa, ma);

      // rd==0 on both ports
      bus.alu_valid_in = 1'b1;
      bus.mem_valid_in = 1'b1;
      bus.alu_data_in  = 32'hDEAD;
      bus.mem_data_in  = 32'hBEEF;
      step(aa, ma);
      chk("r032_acc", {30'd0, aa, ma}, 32'd3);
      chk("r032_we", {31'd0, bus.we_out}, 32'd0);
      idle_in();
      step(aa, ma);
      chk("r032_we2", {31'd0, bus.we_out}, 32'd0);
      chk("r032_mrdy", {31'd0, bus.mem_ready_out}, 32'd1);

      // reset with three queued loads
      for (int k = 0; k < 3; k++) begin
         bus.alu_valid_in = 1'b1;
         bus.alu_rd_in    = 5'd1;
         bus.alu_data_in  = 32'(k);
         bus.mem_valid_in = 1'b1;
         bus.mem_rd_in    = 5'(20 + k);
         bus.mem_data_in  = 32'(100 + k);
         step(aa, ma);
      end
      chk("r033_pend_pre", bus.pending_out, 32'h0070_0000);
      idle_in();
      rst_in = 1'b1;
      step(aa, ma);
      chk("r033_we", {31'd0, bus.we_out}, 32'd0);
      chk("r033_pend", bus.pending_out, 32'd0);
      rst_in = 1'b0;
      #1;
      chk("r033_mrdy", {31'd0, bus.mem_ready_out}, 32'd1);
      step(aa, ma);
      chk("r033_we2", {31'd0, bus.we_out}, 32'd0);

      // random traffic with occasional reset
      left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (aa || !bus.alu_valid_in) begin
            bus.alu_valid_in = ($urandom_range(0, 99) < 60);
            bus.alu_rd_in    = ($urandom_range(0, 9) == 0)
                             ? 5'd0 : 5'($urandom_range(1, 31));
            bus.alu_data_in  = $urandom;
         end
         if (ma || !bus.mem_valid_in) begin
            bus.mem_valid_in = ($urandom_range(0, 99) < 50);
            bus.mem_rd_in    = ($urandom_range(0, 9) == 0)
                             ? 5'd0 : 5'($urandom_range(1, 31));
            bus.mem_data_in  = $urandom;
         end
         if (left > 0) left--;
         else if ($urandom_range(0, 299) == 0) left = 2;
         rst_in = (left > 0);
         step(aa, ma);
      end
      rst_in = 1'b0;
      idle_in();
      step(aa, ma);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
